qupls_fpu_issue_sched: RTL
==========================

// Module: qupls_fpu_issue_sched
// PURPOSE
//  Picks ready FP ops from a window of ROB candidates and issues them to NSTN FPU reservation stations.
//  Drives each station's rndx/rndxv/idle inputs and tracks multicycle occupancy per station.
//  Round-robin fairness across candidate slots. Sits between the ROB ready scan and the FPU stations.
// PARAMETERS
//  NREQ  8  candidate slots scanned per cycle (power of 2, 2..16)
//  NSTN  2  FPU stations served (1..4)
//  LATW  6  width of per-op occupancy count
// PORTS
//  clk           in   1            clock; all logic on rising edge
//  rst           in   1            synchronous reset, active-low (rst==0 resets)
//  flush         in   1            pipeline flush; cancels all occupancy
//  req_v         in   NREQ         candidate slot holds a ready FP op
//  req_ndx       in   NREQ x rob_ndx_t  ROB index per slot
//  req_lat       in   NREQ x LATW  busy cycles after issue; 0 = fully pipelined
//  stn_avail     in   NSTN         station 'available' (unit present/enabled)
//  stn_done      in   NSTN         station sc_done / completion pulse
//  req_grant     out  NREQ         slot granted this cycle (registered; ROB clears slot)
//  stn_rndx      out  NSTN x rob_ndx_t  index issued to station
//  stn_rndxv     out  NSTN         one-cycle issue strobe
//  stn_idle      out  NSTN         station may accept an op
// BEHAVIOUR
//  Reset (rst==0 at clk): req_grant=0, stn_rndxv=0, stn_rndx=0, stn_idle=all-1, rr_ptr=0, counters=0, all FSMs IDLE.
//  Per-station FSM: IDLE -> ISSUE -> (IDLE if lat==0 | BUSY if lat>0); BUSY -> IDLE when cnt==1 or stn_done.
//  - IDLE: stn_idle=1. Eligible for a grant if stn_avail=1.
//  - ISSUE: one cycle. stn_rndxv=1, stn_rndx=granted index. Latch cnt=lat.
//    lat==0 -> stn_idle stays 1, so back-to-back issue every cycle.
//  - BUSY: stn_idle=0. cnt decrements each cycle. Leave at cnt==1 (station idle again exactly lat cycles after ISSUE).
//    stn_done in BUSY -> IDLE next cycle regardless of cnt.
//  Selection (combinational, registered into outputs; issue latency 1 clk from req_v):
//  - Search slots starting at rr_ptr, wrapping mod NREQ.
//  - Station 0 takes the first eligible slot; station 1 the next distinct slot; etc.
//    A slot is never granted to two stations. A slot granted last cycle is masked for one cycle (ROB clear latency).
//  - rr_ptr <= (highest-offset granted slot + 1) mod NREQ; unchanged if nothing granted.
//  - Stations idle/eligible in the same cycle are filled lowest-station-first. A station leaving BUSY this cycle is not eligible until next cycle.
//  flush=1: no grants that cycle; all FSMs -> IDLE; counters cleared; rr_ptr held; stn_rndxv=0 next cycle.
//  Simultaneous flush and stn_done: flush wins (same result).
//  Fewer eligible ops than free stations: higher-numbered stations get no strobe. No req_v: outputs hold except strobes fall to 0.
//  req_lat saturates at 2^LATW-1 (no wrap). stn_avail dropping while BUSY does not abort; blocks the next grant only.
//  Reset mid-BUSY: immediate return to reset state; no pending strobe survives.
// CONFIGURATION
//  QUPLS_FPU_SCHED_PERF_EN defined:
//  - Adds outputs perf_issue[31:0] (total stn_rndxv strobes) and perf_stall[31:0].
//    perf_stall counts cycles with any req_v=1 and zero grants.
//  - Both are wrapping counters, cleared on reset, frozen during flush.
//  Undefined: ports and counters absent; scheduling identical.
// TESTING
//  1. Reset: rst=0 two clocks -> stn_idle=2'b11, stn_rndxv=0, req_grant=0; release, req_v=0 -> no strobes for 10 clks.
//  2. Pipelined fill: req_v=8'h0F, lat=0, ndx=3,4,5,6 -> clk1 stn0 gets 3, stn1 gets 4.
//     Then 5 and 6 next-but-one cycle; rr_ptr ends at 4.
//  3. Multicycle: single op ndx=9 lat=5 to stn0 -> stn_idle[0]=0 for exactly 5 clks after ISSUE.
//     Second req meanwhile goes to stn1.
//  4. Early done: lat=20, stn_done[0] pulsed 3 clks after ISSUE -> stn_idle[0]=1 on the next clk.
//  5. Fairness: all 8 slots always valid, lat=0, NSTN=2 -> each slot granted once per 4 cycles; no slot starves.
//  6. Flush: stn0 BUSY cnt=10, stn1 BUSY; flush=1 with req_v=8'hFF -> no req_grant that clk; both idle next clk.
//     PERF build: perf_stall unchanged.

Source files
------------

// File: rtl/qupls_fpu_issue_sched.sv
// ----------------------------------------------------------------------------
// qupls_fpu_issue_sched
//
// Purpose:
//   Issues ready FP ops from a window of ROB candidate slots to NSTN FPU
//   reservation stations. Each cycle it scans the slots round-robin from
//   rr_ptr and hands distinct slots to the stations that can accept an op,
//   filling the lowest-numbered station first. Each station runs a small FSM
//   (IDLE -> ISSUE -> IDLE/BUSY) that tracks how long a multicycle op keeps
//   it occupied. The selection is combinational. Its result is registered
//   into the outputs, so an op issues one clock after req_v.
//
// Parameters:
//   NREQ  candidate slots scanned per cycle (power of 2, 2..16)
//   NSTN  FPU stations served (1..4)
//   LATW  width of the per-op occupancy count
//   NDXW  width of a ROB index (rob_ndx_t)
//
// Ports:
//   clk        in   clock, all logic on the rising edge
//   rst        in   synchronous reset, active-low
//   flush      in   pipeline flush: no grants, all stations back to IDLE
//   req_v      in   [NREQ]       slot holds a ready FP op
//   req_ndx    in   [NREQ*NDXW]  ROB index per slot (slot i at i*NDXW)
//   req_lat    in   [NREQ*LATW]  busy cycles after issue, 0 = pipelined
//   stn_avail  in   [NSTN]       station unit present/enabled
//   stn_done   in   [NSTN]       station completion pulse (ends BUSY early)
//   req_grant  out  [NREQ]       registered per-slot grant (ROB clears slot)
//   stn_rndx   out  [NSTN*NDXW]  ROB index issued to each station
//   stn_rndxv  out  [NSTN]       one-cycle issue strobe
//   stn_idle   out  [NSTN]       station may accept an op
//
// Optional feature (macro QUPLS_FPU_SCHED_PERF_EN):
//   perf_issue out [32]  total issue strobes (wrapping)
//   perf_stall out [32]  cycles with a ready op but no grant (wrapping)
//   Both counters clear on reset and freeze during flush.
// ----------------------------------------------------------------------------
module qupls_fpu_issue_sched #(
    parameter int NREQ = 8,
    parameter int NSTN = 2,
    parameter int LATW = 6,
    parameter int NDXW = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [NREQ-1:0]      req_v,
    input  logic [NREQ*NDXW-1:0] req_ndx,
    input  logic [NREQ*LATW-1:0] req_lat,
    input  logic [NSTN-1:0]      stn_avail,
    input  logic [NSTN-1:0]      stn_done,
    output logic [NREQ-1:0]      req_grant,
    output logic [NSTN*NDXW-1:0] stn_rndx,
    output logic [NSTN-1:0]      stn_rndxv,
    output logic [NSTN-1:0]      stn_idle
`ifdef QUPLS_FPU_SCHED_PERF_EN
    ,
    output logic [31:0]          perf_issue,
    output logic [31:0]          perf_stall
`endif
);

    localparam int PTRW = $clog2(NREQ);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

    state_t              state     [NSTN];
    state_t              state_nxt [NSTN];
    logic [LATW-1:0]     cnt       [NSTN];
    logic [LATW-1:0]     cnt_nxt   [NSTN];
    logic [PTRW-1:0]     rr_ptr;
    logic [PTRW-1:0]     rr_ptr_nxt;

    logic [NREQ-1:0]     cand;
    logic [NREQ-1:0]     grant_nxt;
    logic [NSTN-1:0]     elig;
    logic [NSTN-1:0]     pick_v;
    logic [PTRW-1:0]     pick_slot [NSTN];
    logic [PTRW-1:0]     slot;
    logic                placed;

    logic [NSTN*NDXW-1:0] rndx_nxt;
    logic [NSTN-1:0]      rndxv_nxt;

    // ------------------------------------------------------------------------
    // Station availability.
    // A station in ISSUE with a zero latency is still idle, which lets a
    // pipelined unit take a new op every cycle. A station in BUSY is never
    // eligible, even in the cycle it leaves BUSY.
    // ------------------------------------------------------------------------
    always_comb begin
        stn_idle = '0;
        for (int s = 0; s < NSTN; s++) begin
            case (state[s])
                ST_IDLE:  stn_idle[s] = 1'b1;
                ST_ISSUE: stn_idle[s] = (cnt[s] == '0);
                default:  stn_idle[s] = 1'b0;
            endcase
        end
        elig = stn_idle & stn_avail;
    end

    // ------------------------------------------------------------------------
    // Round-robin selection.
    // Slots granted last cycle are masked because the ROB has not cleared
    // them yet. Slots are visited in search order from rr_ptr. Each ready
    // slot goes to the lowest free eligible station. Stations are therefore
    // filled in order, so the last slot placed is the highest-offset grant,
    // and rr_ptr moves just past it.
    // ------------------------------------------------------------------------
    always_comb begin
        cand       = req_v & ~req_grant;
        grant_nxt  = '0;
        pick_v     = '0;
        rr_ptr_nxt = rr_ptr;
        slot       = '0;
        placed     = 1'b0;
        for (int s = 0; s < NSTN; s++) begin
            pick_slot[s] = '0;
        end
        if (!flush) begin
            for (int k = 0; k < NREQ; k++) begin
                slot   = rr_ptr + PTRW'(k);
                placed = 1'b0;
                if (cand[slot]) begin
                    for (int s = 0; s < NSTN; s++) begin
                        if (!placed && elig[s] && !pick_v[s]) begin
                            pick_v[s]       = 1'b1;
                            pick_slot[s]    = slot;
                            grant_nxt[slot] = 1'b1;
                            rr_ptr_nxt      = slot + PTRW'(1);
                            placed          = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Per-station next state.
    // The count is loaded with the op latency on issue and decrements every
    // cycle, including the ISSUE cycle. Leaving at cnt==1 makes the station
    // idle again exactly lat cycles after ISSUE. The count is as wide as
    // req_lat, so the largest latency loads unchanged and never wraps.
    // ------------------------------------------------------------------------
    always_comb begin
        rndx_nxt  = stn_rndx;
        rndxv_nxt = '0;
        for (int s = 0; s < NSTN; s++) begin
            state_nxt[s] = state[s];
            cnt_nxt[s]   = cnt[s];
            if (flush) begin
                state_nxt[s] = ST_IDLE;
                cnt_nxt[s]   = '0;
            end else if (pick_v[s]) begin
                state_nxt[s] = ST_ISSUE;
                cnt_nxt[s]   = req_lat[pick_slot[s]*LATW +: LATW];
                rndxv_nxt[s] = 1'b1;
                rndx_nxt[s*NDXW +: NDXW] = req_ndx[pick_slot[s]*NDXW +: NDXW];
            end else begin
                case (state[s])
                    ST_ISSUE: begin
                        if (cnt[s] <= LATW'(1)) begin
                            state_nxt[s] = ST_IDLE;
                            cnt_nxt[s]   = '0;
                        end else begin
                            state_nxt[s] = ST_BUSY;
                            cnt_nxt[s]   = cnt[s] - LATW'(1);
                        end
                    end
                    ST_BUSY: begin
                        if (stn_done[s] || cnt[s] == LATW'(1)) begin
                            state_nxt[s] = ST_IDLE;
                            cnt_nxt[s]   = '0;
                        end else begin
                            cnt_nxt[s]   = cnt[s] - LATW'(1);
                        end
                    end
                    default: begin
                        state_nxt[s] = ST_IDLE;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------------
    // State and output registers.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int s = 0; s < NSTN; s++) begin
                state[s] <= ST_IDLE;
                cnt[s]   <= '0;
            end
            rr_ptr    <= '0;
            req_grant <= '0;
            stn_rndx  <= '0;
            stn_rndxv <= '0;
        end else begin
            for (int s = 0; s < NSTN; s++) begin
                state[s] <= state_nxt[s];
                cnt[s]   <= cnt_nxt[s];
            end
            rr_ptr    <= rr_ptr_nxt;
            req_grant <= grant_nxt;
            stn_rndx  <= rndx_nxt;
            stn_rndxv <= rndxv_nxt;
        end
    end

`ifdef QUPLS_FPU_SCHED_PERF_EN
    // ------------------------------------------------------------------------
    // Performance counters.
    // ------------------------------------------------------------------------
    logic [31:0] issue_inc;

    always_comb begin
        issue_inc = '0;
        for (int s = 0; s < NSTN; s++) begin
            issue_inc = issue_inc + 32'(stn_rndxv[s]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_issue <= '0;
            perf_stall <= '0;
        end else if (!flush) begin
            perf_issue <= perf_issue + issue_inc;
            if (|req_v && grant_nxt == '0) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule
